// File: rtl/triage_alarm_driver.sv
// Triage alarm driver: debounces the triage actuator code, drives the lamps and runs the buzzer/nurse-call FSM.
// Build option: define TRIAGE_ESCALATE_EN to enable the ESCALATE state after three unanswered calls.
module triage_alarm_driver #(
  parameter int STABLE_CYC = 2,
  parameter int BLINK_DIV  = 5,
  parameter int CALL_RETRY = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] a,
  input  logic       ack,
  output logic [1:0] level,
  output logic       led_g,
  output logic       led_y,
  output logic       led_r,
  output logic       buzz,
  output logic       call,
  output logic       esc,
  output logic       fault
);

  // state    | meaning
  // QUIET    | no alarm, buzzer and call idle
  // ALERT    | level >= 2 unacknowledged, buzzer active, periodic calls
  // ACKED    | nurse acknowledged, buzzer silent until level rises
  // ESCALATE | three calls went unanswered, escalation flag raised
`ifdef TRIAGE_ESCALATE_EN
  typedef enum logic [1:0] {QUIET, ALERT, ACKED, ESCALATE} state_t;
`else
  typedef enum logic [1:0] {QUIET, ALERT, ACKED} state_t;
`endif

  localparam int SW = $clog2(STABLE_CYC + 1);
  localparam int BW = $clog2((BLINK_DIV > 1) ? BLINK_DIV : 2);
  localparam int RW = $clog2((CALL_RETRY > 1) ? CALL_RETRY : 2);

  logic [5:0]    a_q;
  logic [SW-1:0] stab_cnt;
  logic [SW-1:0] stab_nxt;
  logic          a_chg;
  logic          accept;
  logic          code_ok;
  logic [1:0]    code_lvl;

  always_comb begin
    a_chg = (a != a_q);
    if (a_chg)
      stab_nxt = SW'(1);
    else if (stab_cnt == SW'(STABLE_CYC))
      stab_nxt = stab_cnt;
    else
      stab_nxt = stab_cnt + SW'(1);
    // fire once per stable run, on the cycle the run length reaches the threshold
    accept = (stab_nxt == SW'(STABLE_CYC)) && (a_chg || (stab_cnt != SW'(STABLE_CYC)));
  end

  always_comb begin
    code_ok  = 1'b1;
    code_lvl = 2'd0;
    case (a)
      6'b000000: code_lvl = 2'd0;
      6'b001100: code_lvl = 2'd1;
      6'b011010: code_lvl = 2'd2;
      6'b111111: code_lvl = 2'd3;
      default:   code_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= 6'b000000;
      stab_cnt <= '0;
      level    <= 2'd0;
      fault    <= 1'b0;
    end else begin
      a_q      <= a;
      stab_cnt <= stab_nxt;
      if (accept) begin
        if (code_ok) begin
          level <= code_lvl;
          fault <= 1'b0;
        end else begin
          fault <= 1'b1;
        end
      end
    end
  end

  logic [BW-1:0] led_cnt;
  logic          led_ph;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_cnt <= '0;
      led_ph  <= 1'b0;
    end else if (!fault) begin
      led_cnt <= '0;
      led_ph  <= 1'b1;
    end else if (led_cnt == BW'(BLINK_DIV - 1)) begin
      led_cnt <= '0;
      led_ph  <= ~led_ph;
    end else begin
      led_cnt <= led_cnt + BW'(1);
    end
  end

  assign led_g = ~fault & (level == 2'd0);
  assign led_y = fault ? led_ph : (level == 2'd1);
  assign led_r = ~fault & level[1];

  state_t        state;
  state_t        nxt;
  logic          fresh;
  logic          restart;
  logic [1:0]    level_d;
  logic [BW-1:0] blink_cnt;
  logic          blink_ph;
  logic          blink_ph_nxt;
  logic [RW-1:0] retry_cnt;
  logic          blink_wrap;
  logic          retry_wrap;
  logic          rise;
  logic          lvl_hi;
`ifdef TRIAGE_ESCALATE_EN
  logic [1:0]    call_num;
`endif

  assign lvl_hi       = level[1];
  assign rise         = (level > level_d);
  assign blink_wrap   = (blink_cnt == BW'(BLINK_DIV - 1));
  assign retry_wrap   = (retry_cnt == RW'(CALL_RETRY - 1));
  assign blink_ph_nxt = blink_wrap ? ~blink_ph : blink_ph;

  // fresh marks an entry that restarts the call schedule, including ALERT re-entry on a level rise
  always_comb begin
    nxt   = state;
    fresh = 1'b0;
    case (state)
      QUIET: begin
        if (lvl_hi) begin
          nxt   = ALERT;
          fresh = 1'b1;
        end
      end
      ALERT: begin
        if (!lvl_hi)
          nxt = QUIET;
        else if (ack && rise)
          fresh = 1'b1;
        else if (ack)
          nxt = ACKED;
`ifdef TRIAGE_ESCALATE_EN
        else if (retry_wrap && (call_num == 2'd3)) begin
          nxt   = ESCALATE;
          fresh = 1'b1;
        end
`endif
      end
      ACKED: begin
        if (!lvl_hi)
          nxt = QUIET;
        else if (rise) begin
          nxt   = ALERT;
          fresh = 1'b1;
        end
      end
`ifdef TRIAGE_ESCALATE_EN
      ESCALATE: begin
        if (!lvl_hi)
          nxt = QUIET;
        else if (ack && rise) begin
          nxt   = ALERT;
          fresh = 1'b1;
        end else if (ack)
          nxt = ACKED;
      end
`endif
      default: nxt = QUIET;
    endcase
    restart = fresh || (nxt != state);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= QUIET;
      level_d   <= 2'd0;
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
      retry_cnt <= '0;
      buzz      <= 1'b0;
      call      <= 1'b0;
    end else begin
      state   <= nxt;
      level_d <= level;
      if (restart) begin
        blink_cnt <= '0;
        blink_ph  <= 1'b1;
        retry_cnt <= '0;
      end else if (nxt != QUIET && nxt != ACKED) begin
        blink_cnt <= blink_wrap ? '0 : blink_cnt + BW'(1);
        blink_ph  <= blink_ph_nxt;
        retry_cnt <= retry_wrap ? '0 : retry_cnt + RW'(1);
      end
      case (nxt)
        ALERT: begin
          if (fresh) begin
            call <= 1'b1;
            buzz <= 1'b1;
          end else begin
            call <= retry_wrap;
            buzz <= (level == 2'd3) | blink_ph_nxt;
          end
        end
`ifdef TRIAGE_ESCALATE_EN
        ESCALATE: begin
          call <= fresh | retry_wrap;
          buzz <= 1'b1;
        end
`endif
        default: begin
          call <= 1'b0;
          buzz <= 1'b0;
        end
      endcase
    end
  end

`ifdef TRIAGE_ESCALATE_EN
  logic esc_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      call_num <= 2'd0;
      esc_r    <= 1'b0;
    end else begin
      esc_r <= (nxt == ESCALATE);
      if (fresh)
        call_num <= 2'd1;
      else if (state == ALERT && retry_wrap && call_num != 2'd3)
        call_num <= call_num + 2'd1;
    end
  end

  assign esc = esc_r;
`else
  assign esc = 1'b0;
`endif

endmodule

// File: doc/triage_alarm_driver.md
TRIAGE_ALARM_DRIVER -- requirements
Module: triage_alarm_driver

Interface
REQ-001 Parameter STABLE_CYC, default 2: consecutive identical samples of A required before a code is accepted.
REQ-002 Parameter BLINK_DIV, default 5: cycles per buzzer half-period in blink mode.
REQ-003 Parameter CALL_RETRY, default 50: cycles between repeated CALL pulses while unacknowledged.
REQ-004 CLK  input  1  system clock, rising-edge active.
REQ-005 RST_N  input  1  reset, asynchronous, active-low.
REQ-006 A  input  6  actuator code from triage_core.
REQ-007 ACK  input  1  nurse acknowledge, sampled each cycle.
REQ-008 LEVEL  output  2  accepted triage level: 0 IDLE, 1 OBSERVATION, 2 PRE_CRITICAL, 3 CRITICAL.
REQ-009 LED_G / LED_Y / LED_R  output  1 each  status lamps.
REQ-010 BUZZ  output  1  audible alarm drive.
REQ-011 CALL  output  1  one-cycle nurse-call pulse.
REQ-012 ESC  output  1  escalation flag.
REQ-013 FAULT  output  1  accepted A code is not a legal triage code.

Function
REQ-014 A is registered once; a stability counter increments while the registered value equals the previous one and reloads on change; the code is accepted when the value has been identical for STABLE_CYC consecutive cycles.
REQ-015 Decode of accepted code: 000000->0, 001100->1, 011010->2, 111111->3; any other code sets FAULT=1 and holds LEVEL at its previous value.
REQ-016 FAULT clears on the cycle a legal code is accepted.
REQ-017 Lamps: LED_G=1 for LEVEL 0, LED_Y=1 for LEVEL 1, LED_R=1 for LEVEL>=2; while FAULT=1, LED_Y toggles every BLINK_DIV cycles and LED_G/LED_R=0.
REQ-018 Alarm FSM states: QUIET, ALERT, ACKED, ESCALATE.
REQ-019 QUIET: BUZZ=0, CALL=0; accepted LEVEL>=2 -> ALERT.
REQ-020 ALERT entry: CALL pulses high for exactly one cycle on the first ALERT cycle, then every CALL_RETRY cycles while in ALERT.
REQ-021 ALERT: BUZZ toggles every BLINK_DIV cycles at LEVEL 2, steady 1 at LEVEL 3.
REQ-022 ALERT: ACK=1 -> ACKED; LEVEL<2 -> QUIET; after the third CALL pulse without ACK, the next retry point -> ESCALATE.
REQ-023 ACKED: BUZZ=0, LED_R per REQ-017; LEVEL rising (2->3) -> ALERT with fresh CALL pulse and retry count 0; LEVEL<2 -> QUIET.
REQ-024 ESCALATE: ESC=1, BUZZ steady 1, CALL pulses every CALL_RETRY cycles; ACK -> ACKED (ESC=0); LEVEL<2 -> QUIET.
REQ-025 Simultaneous ACK and LEVEL increase in same cycle: increase wins (ALERT, fresh CALL); ACK ignored in QUIET.
REQ-026 FAULT does not change FSM state; FSM acts on held LEVEL.
REQ-027 Blink and retry counters reset to 0 on every FSM state change.

Reset
REQ-028 RST_N=0 asynchronously forces: state QUIET, LEVEL=0, LED_G=1, LED_Y=0, LED_R=0, BUZZ=0, CALL=0, ESC=0, FAULT=0, all counters 0, registered A=000000.
REQ-029 Reset mid-ALERT/ESCALATE aborts immediately; after release, STABLE_CYC cycles of a legal code are needed before LEVEL changes.

Configuration
REQ-030 Macro TRIAGE_ESCALATE_EN: defined -> ESCALATE state and retry counting per REQ-022/024; undefined -> ESCALATE absent, ALERT retries CALL indefinitely, ESC tied 0, port list unchanged.

Verification
REQ-031 Reset, A=000000 for 10 cycles -> LEVEL=0, LED_G=1, BUZZ=0, CALL never asserted.
REQ-032 A=011010 held -> LEVEL=2 after 2 cycles + pipeline, single CALL pulse, BUZZ toggling period 10 cycles, LED_R=1.
REQ-033 A=111111 held 200 cycles, no ACK, macro defined -> CALL at entry, +50, +100, +150; ESC=1 at +150; without macro ESC stays 0.
REQ-034 In ALERT LEVEL 2 assert ACK 1 cycle -> BUZZ=0, ACKED; then A=111111 -> ALERT re-entered with new CALL pulse.
REQ-035 A=101010 held -> FAULT=1, LEVEL unchanged, LED_Y blinking; A glitch lasting 1 cycle -> no LEVEL change.
REQ-036 RST_N low mid-ESCALATE -> all outputs at reset values in same cycle, independent of CLK.
